lc4_limb_alu: RTL and testbench
===============================

# lc4_limb_alu

Multi-cycle, limb-serial wide-word add/subtract/negate unit for the ECC datapath. It is the parametrised successor of the single-cycle 256-bit adder path. Each cycle it processes one LIMB_W-bit limb and ripples the carry through a register, which trades latency for a much shorter critical path. It sits beside the register file and takes operands under a start/done handshake from the control unit.

## Interface
- WORD_SIZE, 256, operand/result width in bits
- LIMB_W, 32, limb width per cycle; must divide WORD_SIZE exactly
- NLIMB, WORD_SIZE/LIMB_W, derived localparam; not overridable
- clk  input  1  rising-edge clock; single clock domain
- rst  input  1  asynchronous, active-high reset
- i_start  input  1  request; sampled only when idle
- i_mode  input  2  00 ADD, 01 SUB, 10 TCS (negate), 11 TCDH (conditional complement)
- i_a  input  WORD_SIZE  operand A; sampled on the accepting edge
- i_b  input  WORD_SIZE  operand B; sampled on the accepting edge
- i_carry  input  1  carry-in for ADD; complement selector for TCDH; sampled on the accepting edge
- o_busy  output  1  high while limbs are being processed
- o_done  output  1  one-cycle pulse when the result is complete
- o_result  output  WORD_SIZE  result; stable whenever o_busy=0
- o_carry  output  1  carry out of the MSB limb
- o_zero  output  1  result-is-zero flag (see Configuration)

## Operation
- Clock and reset are fixed: one clock `clk`; `rst` is asynchronous and active-high.
- FSM states:
  - IDLE to RUN when i_start=1. The accepting edge latches the X, Y and cin operands and clears the limb counter.
  - RUN to IDLE on the edge that processes limb NLIMB-1. That edge sets o_done=1.
- Operand forms, all WORD_SIZE wide:
  - ADD: X=A, Y=B, cin=i_carry
  - SUB: X=A, Y=~B, cin=1
  - TCS: X=~A, Y=0, cin=1
  - TCDH: X=~A, Y=0, cin=i_carry
- Per RUN edge k (k=0..NLIMB-1, LSB limb first):
  - {c, limb} = X[k] + Y[k] + c, computed LIMB_W+1 bits wide.
  - The limb shifts into o_result from the top. X and Y shift right by LIMB_W.
- Final state: o_carry = c after limb NLIMB-1. For SUB, o_carry=1 means no borrow (A>=B).
- Arithmetic is modulo 2^WORD_SIZE. There is no overflow flag.
- i_start is ignored while o_busy=1. Operands may change freely after the accepting edge.
- A start is accepted in the cycle o_done is high, because the FSM is already in IDLE. The run is then back-to-back. o_result may change from the next edge onward.
- Limb counter width is max(1, clog2(NLIMB)).
- NLIMB=1 is legal: the unit degenerates to a single RUN cycle.

## Timing
- Reset values: FSM IDLE, o_busy 0, o_done 0, o_result 0, o_carry 0, o_zero 0, internal carry 0.
- Start sampled at edge E0:
  - o_busy is high from after E0 through edge E_NLIMB.
  - o_done is high for the single cycle following edge E_NLIMB.
  - Latency is NLIMB cycles (8 at the defaults).
- o_result, o_carry and o_zero are valid from the o_done cycle. They hold until the edge after the next accepted start.
- Reset asserted mid-RUN aborts the run immediately: all outputs return to reset values and no o_done is issued.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- LIMB_ALU_ZFLAG_EN defined:
  - A zero accumulator is set to 1 on the accepting edge and ANDed with (limb==0) on each RUN edge.
  - o_zero = 1 iff o_result == 0, and is valid with o_done.
  - o_zero is reset to 0 and is updated only when a run completes.
- LIMB_ALU_ZFLAG_EN undefined: o_zero is tied to 0 and no accumulator is built.

## Test plan
- ADD, A=2^256-1, B=1, i_carry=0 → o_result=0, o_carry=1, o_done exactly 8 cycles after start, o_zero=1 (macro on).
- Limb-boundary carry: ADD, A=0xFFFFFFFF, B=1 → o_result=0x1_0000_0000, o_carry=0. SUB, A=5, B=7 → o_result=2^256-2, o_carry=0.
- Negation modes:
  - TCS, A=1 → all ones, o_carry=0.
  - TCS, A=0 → 0, o_carry=1.
  - TCDH, A=0, i_carry=0 → all ones, o_carry=0.
  - TCDH, A=0, i_carry=1 → 0, o_carry=1.
- Handshake:
  - i_start pulsed at cycle 3 of a run with different operands → ignored, first result unchanged.
  - i_start during the o_done cycle → second run accepted, second o_done 8 cycles later.
- rst asserted after limb 4 of a run → all outputs 0 immediately, o_busy 0, no o_done. The next start after release completes normally.
- Parameter sweep with LIMB_W=256 (NLIMB=1) and LIMB_W=8 (NLIMB=32), random operands in all four modes → results match the reference model, latency = NLIMB.

Source files
------------

// File: rtl/lc4_limb_alu.sv
// lc4_limb_alu: limb-serial wide-word add / subtract / negate unit.
//
// One LIMB_W-bit limb is processed per cycle, least significant limb first.
// The carry ripples between limbs through a register.
// A run is started with i_start while idle.
// o_done pulses for one cycle NLIMB cycles after the accepting edge.
//
// Ports
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   i_start    request, sampled only when idle
//   i_mode     00 ADD, 01 SUB, 10 TCS (negate), 11 TCDH (conditional complement)
//   i_a, i_b   operands, sampled on the accepting edge
//   i_carry    ADD carry-in / TCDH complement selector
//   o_busy     high while limbs are being processed
//   o_done     one-cycle completion pulse
//   o_result   result, stable while o_busy is low
//   o_carry    carry out of the most significant limb (SUB: 1 means A >= B)
//   o_zero     result-is-zero flag
//
// Optional feature: define LIMB_ALU_ZFLAG_EN to build the zero flag.
// Without it, o_zero is tied low.
module lc4_limb_alu #(
  parameter int unsigned WORD_SIZE = 256,
  parameter int unsigned LIMB_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [1:0]           i_mode,
  input  logic [WORD_SIZE-1:0] i_a,
  input  logic [WORD_SIZE-1:0] i_b,
  input  logic                 i_carry,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [WORD_SIZE-1:0] o_result,
  output logic                 o_carry,
  output logic                 o_zero
);

  localparam int unsigned NLIMB = WORD_SIZE / LIMB_W;
  localparam int unsigned CntW  = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NLIMB - 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] x_q, x_d, y_q, y_d, result_q, result_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 c_q, c_d, busy_q, busy_d, done_q, done_d, carry_q, carry_d;

  logic [LIMB_W-1:0]    limb;
  logic                 c_sum;
  logic [WORD_SIZE-1:0] limb_top;
  logic                 accept, last_limb, running;

  assign {c_sum, limb} = {1'b0, x_q[LIMB_W-1:0]} + {1'b0, y_q[LIMB_W-1:0]}
                         + {{LIMB_W{1'b0}}, c_q};
  // The new limb enters at the top, so after NLIMB shifts limb 0 sits at the bottom.
  assign limb_top  = WORD_SIZE'(limb) << (WORD_SIZE - LIMB_W);
  assign accept    = (state_q == StIdle) && i_start;
  assign running   = (state_q == StRun);
  assign last_limb = running && (cnt_q == LastCnt);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    carry_d  = carry_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StRun;
          busy_d  = 1'b1;
          cnt_d   = '0;
          unique case (i_mode)
            2'b00: begin x_d = i_a;  y_d = i_b;  c_d = i_carry; end
            2'b01: begin x_d = i_a;  y_d = ~i_b; c_d = 1'b1;    end
            2'b10: begin x_d = ~i_a; y_d = '0;   c_d = 1'b1;    end
            default: begin x_d = ~i_a; y_d = '0; c_d = i_carry; end
          endcase
        end
      end
      StRun: begin
        x_d      = x_q >> LIMB_W;
        y_d      = y_q >> LIMB_W;
        c_d      = c_sum;
        result_d = (result_q >> LIMB_W) | limb_top;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          carry_d = c_sum;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      carry_q  <= carry_d;
    end
  end

`ifdef LIMB_ALU_ZFLAG_EN
  // The accumulator stays high only while every limb produced so far is zero.
  logic zacc_q, zacc_d, zero_q, zero_d;

  always_comb begin
    zacc_d = zacc_q;
    zero_d = zero_q;
    if (accept) begin
      zacc_d = 1'b1;
    end else if (running) begin
      zacc_d = zacc_q & (limb == '0);
      if (last_limb) zero_d = zacc_q & (limb == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zacc_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      zacc_q <= zacc_d;
      zero_q <= zero_d;
    end
  end

  assign o_zero = zero_q;
`else
  assign o_zero = 1'b0;
`endif

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_result = result_q;
  assign o_carry  = carry_q;

endmodule

// File: tb/tb_lc4_limb_alu.sv
module tb_lc4_limb_alu;

  localparam int W = 256;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [2:0]     start = 3'b000;
  logic [1:0]     mode = 2'b00;
  logic [W-1:0]   a_i = '0;
  logic [W-1:0]   b_i = '0;
  logic           cin = 1'b0;

  logic [2:0]     busy_w, done_w, carry_w, zero_w;
  logic [W-1:0]   res_w [3];

  int checks = 0;
  int errors = 0;
  int nlimb [3] = '{8, 1, 32};

  always #5 clk = ~clk;

  lc4_limb_alu #(.WORD_SIZE(W), .LIMB_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .i_start(start[0]), .i_mode(mode), .i_a(a_i), .i_b(b_i),
    .i_carry(cin), .o_busy(busy_w[0]), .o_done(done_w[0]), .o_result(res_w[0]),
    .o_carry(carry_w[0]), .o_zero(zero_w[0]));

  lc4_limb_alu #(.WORD_SIZE(W), .LIMB_W(256)) u_dut256 (
    .clk(clk), .rst(rst), .i_start(start[1]), .i_mode(mode), .i_a(a_i), .i_b(b_i),
    .i_carry(cin), .o_busy(busy_w[1]), .o_done(done_w[1]), .o_result(res_w[1]),
    .o_carry(carry_w[1]), .o_zero(zero_w[1]));

  lc4_limb_alu #(.WORD_SIZE(W), .LIMB_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .i_start(start[2]), .i_mode(mode), .i_a(a_i), .i_b(b_i),
    .i_carry(cin), .o_busy(busy_w[2]), .o_done(done_w[2]), .o_result(res_w[2]),
    .o_carry(carry_w[2]), .o_zero(zero_w[2]));

  // Reference: returns {carry, result} from the arithmetic meaning of each mode.
  function automatic logic [W:0] model(input logic [1:0] m, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic c);
    logic [W:0] s;
    case (m)
      2'd0: s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      2'd1: begin s[W-1:0] = a - b; s[W] = (a >= b); end
      2'd2: begin s[W-1:0] = 0 - a; s[W] = (a == 0); end
      default: begin
        if (c) begin s[W-1:0] = 0 - a; s[W] = (a == 0); end
        else   begin s[W-1:0] = ~a;    s[W] = 1'b0;     end
      end
    endcase
    return s;
  endfunction

  function automatic logic zmodel(input logic [W-1:0] r);
`ifdef LIMB_ALU_ZFLAG_EN
    return (r == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [W-1:0] rnd256();
    logic [W-1:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic start_op(input int id, input logic [1:0] m, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic c);
    @(negedge clk);
    mode = m; a_i = a; b_i = b; cin = c;
    start[id] = 1'b1;
    @(negedge clk);
    start[id] = 1'b0;
    // Operands may change freely once accepted.
    a_i = rnd256(); b_i = rnd256(); cin = $urandom_range(0, 1); mode = 2'($urandom);
  endtask

  task automatic wait_done(input int id, inout int n);
    while (done_w[id] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks += 4;
      if (busy_w[i] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d] got %b exp 0", i, busy_w[i]); end
      if (done_w[i] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d] got %b exp 0", i, done_w[i]); end
      if (res_w[i] !== '0) begin errors++; $display("FAIL reset_result[%0d] got %h exp 0", i, res_w[i]); end
      if ({carry_w[i], zero_w[i]} !== 2'b00) begin
        errors++; $display("FAIL reset_flags[%0d] got %b exp 00", i, {carry_w[i], zero_w[i]});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [8];
    logic [W-1:0] tb [8];
    logic [1:0]   tm [8];
    logic         tc [8];
    logic [W:0]   exp;
    int n;
    ta[0] = '1;            tb[0] = 1; tm[0] = 0; tc[0] = 0;
    ta[1] = 'hFFFFFFFF;    tb[1] = 1; tm[1] = 0; tc[1] = 0;
    ta[2] = 5;             tb[2] = 7; tm[2] = 1; tc[2] = 0;
    ta[3] = 1;             tb[3] = 0; tm[3] = 2; tc[3] = 0;
    ta[4] = 0;             tb[4] = 0; tm[4] = 2; tc[4] = 0;
    ta[5] = 0;             tb[5] = 0; tm[5] = 3; tc[5] = 0;
    ta[6] = 0;             tb[6] = 0; tm[6] = 3; tc[6] = 1;
    ta[7] = 9;             tb[7] = 9; tm[7] = 1; tc[7] = 0;
    for (int t = 0; t < 8; t++) begin
      exp = model(tm[t], ta[t], tb[t], tc[t]);
      start_op(0, tm[t], ta[t], tb[t], tc[t]);
      checks++;
      if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL dir%0d_busy got %b exp 1", t, busy_w[0]); end
      n = 0;
      wait_done(0, n);
      checks += 4;
      if (n != 8) begin errors++; $display("FAIL dir%0d_latency got %0d exp 8", t, n); end
      if (res_w[0] !== exp[W-1:0]) begin
        errors++; $display("FAIL dir%0d_result got %h exp %h", t, res_w[0], exp[W-1:0]);
      end
      if (carry_w[0] !== exp[W]) begin errors++; $display("FAIL dir%0d_carry got %b exp %b", t, carry_w[0], exp[W]); end
      if (zero_w[0] !== zmodel(exp[W-1:0])) begin
        errors++; $display("FAIL dir%0d_zero got %b exp %b", t, zero_w[0], zmodel(exp[W-1:0]));
      end
      @(negedge clk);
      checks++;
      if ({done_w[0], busy_w[0]} !== 2'b00) begin
        errors++; $display("FAIL dir%0d_pulse got done/busy %b exp 00", t, {done_w[0], busy_w[0]});
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] a1, b1;
    logic [W:0]   exp;
    int n;
    a1 = rnd256(); b1 = rnd256();
    exp = model(2'd0, a1, b1, 1'b1);
    start_op(0, 2'd0, a1, b1, 1'b1);
    repeat (3) @(negedge clk);
    mode = 2'd1; a_i = rnd256(); b_i = rnd256(); start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n = 4;
    wait_done(0, n);
    checks += 3;
    if (n != 8) begin errors++; $display("FAIL ignore_latency got %0d exp 8", n); end
    if (res_w[0] !== exp[W-1:0]) begin errors++; $display("FAIL ignore_result got %h exp %h", res_w[0], exp[W-1:0]); end
    if (carry_w[0] !== exp[W]) begin errors++; $display("FAIL ignore_carry got %b exp %b", carry_w[0], exp[W]); end
    repeat (2) @(negedge clk);
    checks++;
    if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL ignore_restart got busy %b exp 0", busy_w[0]); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a2, b2;
    logic [W:0]   e1, e2;
    int n;
    e1 = model(2'd1, 256'd100, 256'd3, 1'b0);
    a2 = rnd256(); b2 = rnd256();
    e2 = model(2'd0, a2, b2, 1'b0);
    start_op(0, 2'd1, 256'd100, 256'd3, 1'b0);
    n = 0;
    wait_done(0, n);
    checks += 2;
    if (n != 8) begin errors++; $display("FAIL b2b_lat1 got %0d exp 8", n); end
    if (res_w[0] !== e1[W-1:0]) begin errors++; $display("FAIL b2b_res1 got %h exp %h", res_w[0], e1[W-1:0]); end
    mode = 2'd0; a_i = a2; b_i = b2; cin = 1'b0; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    checks++;
    if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy %b exp 1", busy_w[0]); end
    n = 0;
    wait_done(0, n);
    checks += 3;
    if (n != 8) begin errors++; $display("FAIL b2b_lat2 got %0d exp 8", n); end
    if (res_w[0] !== e2[W-1:0]) begin errors++; $display("FAIL b2b_res2 got %h exp %h", res_w[0], e2[W-1:0]); end
    if (carry_w[0] !== e2[W]) begin errors++; $display("FAIL b2b_carry2 got %b exp %b", carry_w[0], e2[W]); end
  endtask

  task automatic test_reset_mid_run();
    logic [W:0] exp;
    logic       saw_done;
    int n;
    start_op(0, 2'd0, '1, 256'd1, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checks += 2;
    if ({busy_w[0], done_w[0], carry_w[0], zero_w[0]} !== 4'b0000) begin
      errors++; $display("FAIL midrst_flags got %b exp 0000", {busy_w[0], done_w[0], carry_w[0], zero_w[0]});
    end
    if (res_w[0] !== '0) begin errors++; $display("FAIL midrst_result got %h exp 0", res_w[0]); end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_w[0] === 1'b1 || busy_w[0] === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL midrst_nodone got activity %b exp 0", saw_done); end
    exp = model(2'd2, 256'd12345, '0, 1'b0);
    start_op(0, 2'd2, 256'd12345, '0, 1'b0);
    n = 0;
    wait_done(0, n);
    checks += 2;
    if (n != 8) begin errors++; $display("FAIL midrst_latency got %0d exp 8", n); end
    if ({carry_w[0], res_w[0]} !== exp) begin
      errors++; $display("FAIL midrst_run got %h exp %h", {carry_w[0], res_w[0]}, exp);
    end
  endtask

  task automatic test_sweep();
    logic [W-1:0] a, b;
    logic         c;
    logic [W:0]   exp;
    int n;
    for (int id = 0; id < 3; id++) begin
      for (int m = 0; m < 4; m++) begin
        for (int it = 0; it < 4; it++) begin
          a = rnd256(); b = rnd256(); c = 1'($urandom_range(0, 1));
          if (it == 1) b = a;
          if (it == 2) a = '0;
          exp = model(2'(m), a, b, c);
          start_op(id, 2'(m), a, b, c);
          n = 0;
          wait_done(id, n);
          checks += 3;
          if (n != nlimb[id]) begin
            errors++; $display("FAIL sweep_lat d%0d m%0d got %0d exp %0d", id, m, n, nlimb[id]);
          end
          if ({carry_w[id], res_w[id]} !== exp) begin
            errors++; $display("FAIL sweep_res d%0d m%0d got %h exp %h", id, m, {carry_w[id], res_w[id]}, exp);
          end
          if (zero_w[id] !== zmodel(exp[W-1:0])) begin
            errors++; $display("FAIL sweep_zero d%0d m%0d got %b exp %b", id, m, zero_w[id], zmodel(exp[W-1:0]));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
